sti_dac_gen: RTL and testbench

- Parametrised successor to the fixed 16-bit serial-transmit / pixel-DAC pair.
- Accepts parallel frames through a ready/load handshake and serialises each frame in a programmable length, fill and bit order.
- Re-packs the serial stream into PIX_W-bit pixels and writes them checkerboard-interleaved into NUM_BANKS memory banks.
- Zero-pads any unwritten pixels after the last frame, then raises oem_finish.

---
 rtl/sti_dac_pkg.sv | 21 ++
 rtl/sti_dac_bankmap.sv | 28 ++
 rtl/sti_dac_gen.sv | 186 ++++++++++++++++++
 tb/tb_sti_dac_gen.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sti_dac_pkg.sv
// Shared types and helpers for the serial-transmit / pixel-DAC generator.
package sti_dac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAD   = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [1:0] LEN_HALF = 2'd0;
    localparam logic [1:0] LEN_FULL = 2'd1;
    localparam logic [1:0] LEN_1P5  = 2'd2;
    localparam logic [1:0] LEN_DBL  = 2'd3;

    // Serial frame length in bits for a given length code.
    function automatic int unsigned frame_bits(input logic [1:0] len, input int unsigned data_w);
        return (data_w / 2) * (32'(len) + 32'd1);
    endfunction

endpackage

// File: rtl/sti_dac_bankmap.sv
// Pixel index -> checkerboard bank strobe and word address.
module sti_dac_bankmap #(
    parameter int NUM_BANKS  = 8,
    parameter int BANK_DEPTH = 32,
    parameter int ROW_W      = 16,
    parameter int IDX_W      = $clog2(NUM_BANKS * BANK_DEPTH),
    parameter int ADDR_W     = $clog2(BANK_DEPTH)
) (
    input  logic [IDX_W-1:0]     pix_i,
    output logic [NUM_BANKS-1:0] bank_oh_o,
    output logic [ADDR_W-1:0]    addr_o
);
    localparam int GRP_SH = $clog2(2 * BANK_DEPTH);

    logic [GRP_SH-1:0] q;
    logic              row_odd;
    logic [IDX_W-1:0]  bidx;

    always_comb begin
        q         = pix_i[GRP_SH-1:0];
        // Row parity is bit log2(ROW_W) of q; a row spanning the whole pair is always even.
        row_odd   = |(q & GRP_SH'(ROW_W));
        bidx      = ((pix_i >> GRP_SH) << 1) | IDX_W'(q[0] ^ row_odd);
        addr_o    = q[GRP_SH-1:1];
        bank_oh_o = NUM_BANKS'(1) << bidx;
    end

endmodule

// File: rtl/sti_dac_gen.sv
// Frame serialiser with pixel re-packing into checkerboard-interleaved banks,
// zero padding of the remaining image and a sticky finish flag.
module sti_dac_gen #(
    parameter int DATA_W     = 16,
    parameter int PIX_W      = 8,
    parameter int NUM_BANKS  = 8,
    parameter int BANK_DEPTH = 32,
    parameter int ROW_W      = 16,
    parameter int ADDR_W     = $clog2(BANK_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    output logic                 pi_ready,
    input  logic [DATA_W-1:0]    pi_data,
    input  logic [1:0]           pi_length,
    input  logic                 pi_fill,
    input  logic                 pi_msb,
    input  logic                 pi_low,
    input  logic                 pi_end,
    output logic                 so_data,
    output logic                 so_valid,
    output logic [PIX_W-1:0]     oem_dataout,
    output logic [ADDR_W-1:0]    oem_addr,
    output logic [NUM_BANKS-1:0] oem_wr,
    output logic                 oem_finish
);
    import sti_dac_pkg::*;

    localparam int FR_W  = 2 * DATA_W;
    localparam int HALF  = DATA_W / 2;
    localparam int TOTAL = NUM_BANKS * BANK_DEPTH;
    localparam int P_W   = $clog2(TOTAL + 1);
    localparam int IDX_W = $clog2(TOTAL);
    localparam int BL_W  = $clog2(FR_W);
    localparam int FL_W  = BL_W + 1;
    localparam int PC_W  = $clog2(PIX_W);

    state_e                 state_q;
    logic                   pi_ready_q;
    logic                   so_data_q;
    logic                   so_valid_q;
    logic [FR_W-1:0]        sh_q;
    logic                   msb_q;
    logic                   end_q;
    logic [BL_W-1:0]        bl_q;
    logic [PIX_W-1:0]       acc_q;
    logic [PC_W-1:0]        bitcnt_q;
    logic [P_W-1:0]         p_q;
    logic [NUM_BANKS-1:0]   wr_q;
    logic [PIX_W-1:0]       dout_q;
    logic [ADDR_W-1:0]      addr_q;
    logic                   fin_q;

    logic [FR_W-1:0]        frame_d;
    logic [FR_W-1:0]        align_d;
    logic [FL_W-1:0]        flen_d;
    logic [PIX_W-1:0]       acc_d;
    logic                   pix_done_d;
    logic                   room_d;
    logic [P_W-1:0]         p_d;
    logic [NUM_BANKS-1:0]   map_oh;
    logic [ADDR_W-1:0]      map_addr;

    // Expand the payload into an F-bit frame, right-aligned in a 2*DATA_W register.
    always_comb begin
        flen_d  = FL_W'(frame_bits(pi_length, DATA_W));
        frame_d = '0;
        case (pi_length)
            LEN_HALF: frame_d[HALF-1:0] = pi_low ? pi_data[HALF-1:0] : pi_data[DATA_W-1:HALF];
            LEN_FULL: frame_d[DATA_W-1:0] = pi_data;
            LEN_1P5: begin
                if (pi_fill) frame_d[DATA_W+HALF-1:HALF] = pi_data;
                else         frame_d[DATA_W-1:0]         = pi_data;
            end
            LEN_DBL: begin
                if (pi_fill) frame_d[FR_W-1:DATA_W] = pi_data;
                else         frame_d[DATA_W-1:0]    = pi_data;
            end
        endcase
        // MSB-first frames are left-aligned so both orders shift out of a fixed end.
        align_d = pi_msb ? (frame_d << (FL_W'(FR_W) - flen_d)) : frame_d;
    end

    always_comb begin
        acc_d      = {acc_q[PIX_W-2:0], so_data_q};
        pix_done_d = so_valid_q && (bitcnt_q == PC_W'(PIX_W - 1));
        room_d     = (p_q < P_W'(TOTAL));
        p_d        = p_q + P_W'(pix_done_d && room_d);
    end

    sti_dac_bankmap #(
        .NUM_BANKS  (NUM_BANKS),
        .BANK_DEPTH (BANK_DEPTH),
        .ROW_W      (ROW_W),
        .IDX_W      (IDX_W),
        .ADDR_W     (ADDR_W)
    ) u_map (
        .pix_i     (p_q[IDX_W-1:0]),
        .bank_oh_o (map_oh),
        .addr_o    (map_addr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pi_ready_q <= 1'b1;
            so_data_q  <= 1'b0;
            so_valid_q <= 1'b0;
            sh_q       <= '0;
            msb_q      <= 1'b0;
            end_q      <= 1'b0;
            bl_q       <= '0;
            acc_q      <= '0;
            bitcnt_q   <= '0;
            p_q        <= '0;
            wr_q       <= '0;
            dout_q     <= '0;
            addr_q     <= '0;
            fin_q      <= 1'b0;
        end else begin
            wr_q  <= '0;
            fin_q <= (state_q == DONE);
            p_q   <= p_d;
            if (so_valid_q) begin
                acc_q    <= acc_d;
                bitcnt_q <= pix_done_d ? '0 : bitcnt_q + PC_W'(1);
            end
            // Completed pixel is written next cycle, whatever state follows.
            if (pix_done_d && room_d) begin
                wr_q   <= map_oh;
                dout_q <= acc_d;
                addr_q <= map_addr;
            end
            case (state_q)
                IDLE: begin
                    if (load) begin
                        so_valid_q <= 1'b1;
                        so_data_q  <= pi_msb ? align_d[FR_W-1] : align_d[0];
                        sh_q       <= pi_msb ? (align_d << 1) : (align_d >> 1);
                        bl_q       <= BL_W'(flen_d - FL_W'(1));
                        msb_q      <= pi_msb;
                        end_q      <= pi_end;
                        pi_ready_q <= 1'b0;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bl_q != '0) begin
                        so_data_q <= msb_q ? sh_q[FR_W-1] : sh_q[0];
                        sh_q      <= msb_q ? (sh_q << 1) : (sh_q >> 1);
                        bl_q      <= bl_q - BL_W'(1);
                    end else begin
                        so_valid_q <= 1'b0;
                        so_data_q  <= 1'b0;
                        if (!end_q) begin
                            state_q    <= IDLE;
                            pi_ready_q <= 1'b1;
                        end else if (p_d < P_W'(TOTAL)) begin
                            state_q <= PAD;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                PAD: begin
                    wr_q   <= map_oh;
                    dout_q <= '0;
                    addr_q <= map_addr;
                    p_q    <= p_q + P_W'(1);
                    if (p_q == P_W'(TOTAL - 1)) state_q <= DONE;
                end
                DONE: ;
            endcase
        end
    end

    assign pi_ready    = pi_ready_q;
    assign so_data     = so_data_q;
    assign so_valid    = so_valid_q;
    assign oem_dataout = dout_q;
    assign oem_addr    = addr_q;
    assign oem_wr      = wr_q;
    assign oem_finish  = fin_q;

endmodule

// File: tb/tb_sti_dac_gen.sv
// Self-checking bench: frame-level reference model plus directed literal checks.
module tb_sti_dac_gen;
    localparam int TOTAL = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] pi_data = '0;
    logic [1:0]  pi_length = '0;
    logic        pi_fill = 1'b0, pi_msb = 1'b0, pi_low = 1'b0, pi_end = 1'b0;
    logic        pi_ready, so_data, so_valid, oem_finish;
    logic [7:0]  oem_dataout;
    logic [4:0]  oem_addr;
    logic [7:0]  oem_wr;

    sti_dac_gen #(
        .DATA_W(16), .PIX_W(8), .NUM_BANKS(8), .BANK_DEPTH(32), .ROW_W(16), .ADDR_W(5)
    ) dut (
        .clk(clk), .reset(reset), .load(load), .pi_ready(pi_ready),
        .pi_data(pi_data), .pi_length(pi_length), .pi_fill(pi_fill),
        .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
        .so_data(so_data), .so_valid(so_valid), .oem_dataout(oem_dataout),
        .oem_addr(oem_addr), .oem_wr(oem_wr), .oem_finish(oem_finish)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] oh;
        logic [4:0] addr;
        logic [7:0] data;
        int         cyc;
    } wr_t;

    logic        exp_bits[$];
    wr_t         exp_wr[$];
    wr_t         wr_log[$];
    int          n_cmp = 0, n_bad = 0, cyc = 0;
    bit          chk_en = 1'b0;
    int          m_p, m_nb, ser_nb, ser_pix;
    logic [7:0]  m_acc;
    bit          wr_due;
    logic [31:0] cap;
    int          last_bit_cyc;
    logic        cmp_b;
    wr_t         cmp_w;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm, input string msg);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s (cycle %0d)", nm, msg, cyc);
    endtask

    // Reference model: frame -> bit stream -> pixels -> bank/addr by plain arithmetic.
    task automatic push_wr(input int p, input logic [7:0] d);
        wr_t w;
        int  q, bank;
        q      = p % 64;
        bank   = 2 * (p / 64) + ((q % 2) ^ ((q / 16) % 2));
        w.oh   = 8'(1 << bank);
        w.addr = 5'(q / 2);
        w.data = d;
        w.cyc  = 0;
        exp_wr.push_back(w);
    endtask

    task automatic model_frame(input logic [15:0] d, input logic [1:0] len,
                               input logic fill, input logic msb, input logic low, input logic endf);
        logic [31:0] fr;
        int          f;
        logic        b;
        f = 8 * (int'(len) + 1);
        case (len)
            2'd0:    fr = low ? {24'h0, d[7:0]} : {24'h0, d[15:8]};
            2'd1:    fr = {16'h0, d};
            2'd2:    fr = fill ? {8'h0, d, 8'h0} : {16'h0, d};
            default: fr = fill ? {d, 16'h0} : {16'h0, d};
        endcase
        for (int i = 0; i < f; i++) begin
            b = msb ? fr[f-1-i] : fr[i];
            exp_bits.push_back(b);
            m_acc = {m_acc[6:0], b};
            m_nb++;
            if (m_nb == 8) begin
                m_nb = 0;
                if (m_p < TOTAL) begin
                    push_wr(m_p, m_acc);
                    m_p++;
                end
            end
        end
        if (endf) begin
            while (m_p < TOTAL) begin
                push_wr(m_p, 8'h00);
                m_p++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (wr_due) chk("wr_timing", 64'(oem_wr != 8'h0), 64'd1);
            wr_due = 1'b0;
            if (so_valid) begin
                if (exp_bits.size() == 0) fail_now("so_extra_bit", "so_valid high with no bit expected");
                else begin
                    cmp_b = exp_bits.pop_front();
                    chk("so_data", 64'(so_data), 64'(cmp_b));
                end
                ser_nb++;
                if (ser_nb == 8) begin
                    ser_nb = 0;
                    if (ser_pix < TOTAL) wr_due = 1'b1;
                    ser_pix++;
                end
            end
            if (oem_wr != 8'h0) begin
                cmp_w.oh = oem_wr; cmp_w.addr = oem_addr; cmp_w.data = oem_dataout; cmp_w.cyc = cyc;
                wr_log.push_back(cmp_w);
                if (exp_wr.size() == 0) fail_now("wr_extra", "unexpected bank write");
                else begin
                    cmp_w = exp_wr.pop_front();
                    chk("wr_bank", 64'(oem_wr), 64'(cmp_w.oh));
                    chk("wr_addr", 64'(oem_addr), 64'(cmp_w.addr));
                    chk("wr_data", 64'(oem_dataout), 64'(cmp_w.data));
                end
            end
        end
    end

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_pi_ready"}, 64'(pi_ready), 64'd1);
        chk({tag, "_so_valid"}, 64'(so_valid), 64'd0);
        chk({tag, "_so_data"}, 64'(so_data), 64'd0);
        chk({tag, "_oem_wr"}, 64'(oem_wr), 64'd0);
        chk({tag, "_oem_addr"}, 64'(oem_addr), 64'd0);
        chk({tag, "_oem_dataout"}, 64'(oem_dataout), 64'd0);
        chk({tag, "_oem_finish"}, 64'(oem_finish), 64'd0);
    endtask

    task automatic clear_model();
        exp_bits.delete(); exp_wr.delete(); wr_log.delete();
        m_p = 0; m_nb = 0; m_acc = 8'h0; ser_nb = 0; ser_pix = 0; wr_due = 1'b0;
    endtask

    task automatic do_reset();
        chk_en = 1'b0; load = 1'b0; reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outs("rst");
        reset = 1'b0;
        clear_model();
        chk_en = 1'b1;
    endtask

    task automatic send(input logic [15:0] d, input logic [1:0] len, input logic fill,
                        input logic msb, input logic low, input logic endf, input bit glitch,
                        output int nv, output int lcyc);
        int t;
        @(negedge clk);
        t = 0;
        while (!pi_ready && t < 200) begin @(negedge clk); t++; end
        if (!pi_ready) fail_now("ready_timeout", "pi_ready never rose");
        pi_data = d; pi_length = len; pi_fill = fill; pi_msb = msb; pi_low = low; pi_end = endf;
        load = 1'b1;
        lcyc = cyc;
        model_frame(d, len, fill, msb, low, endf);
        @(negedge clk);
        load = 1'b0;
        chk("first_bit_latency", 64'(so_valid), 64'd1);
        nv = 0; cap = '0; t = 0;
        while (t < 100) begin
            if (so_valid) begin
                nv++;
                cap = {cap[30:0], so_data};
                last_bit_cyc = cyc;
            end else if (nv > 0) break;
            if (glitch && nv == 4) begin load = 1'b1; pi_length = 2'd3; pi_data = 16'hFFFF; end
            else load = 1'b0;
            @(negedge clk);
            t++;
        end
        load = 1'b0;
        if (t >= 100) fail_now("frame_timeout", "so_valid never dropped");
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int nv, lc, t, fin_cyc;
        bit any_wr, any_fin;

        // Half frame, low half, MSB first.
        do_reset();
        send(16'hA53C, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, nv, lc);
        chk("t1_nvalid", 64'(nv), 64'd8);
        chk("t1_bits", 64'(cap[7:0]), 64'h3C);
        chk("t1_wr_count", 64'(wr_log.size()), 64'd1);
        if (wr_log.size() >= 1) begin
            chk("t1_wr_data", 64'(wr_log[0].data), 64'h3C);
            chk("t1_wr_bank", 64'(wr_log[0].oh), 64'h01);
            chk("t1_wr_addr", 64'(wr_log[0].addr), 64'd0);
            chk("t1_wr_cycle", 64'(wr_log[0].cyc - last_bit_cyc), 64'd1);
        end

        // 1.5 frame, fill high, LSB first.
        do_reset();
        send(16'h1234, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, nv, lc);
        chk("t2_nvalid", 64'(nv), 64'd24);
        chk("t2_bits", 64'(cap[23:0]), 64'h002C48);
        chk("t2_wr_count", 64'(wr_log.size()), 64'd3);
        if (wr_log.size() >= 3) begin
            chk("t2_w0", 64'({wr_log[0].oh, 3'b0, wr_log[0].addr, wr_log[0].data}), 64'h01_00_00);
            chk("t2_w1", 64'({wr_log[1].oh, 3'b0, wr_log[1].addr, wr_log[1].data}), 64'h02_00_2C);
            chk("t2_w2", 64'({wr_log[2].oh, 3'b0, wr_log[2].addr, wr_log[2].data}), 64'h01_01_48);
        end

        // Double frame, zeros above, MSB first.
        do_reset();
        send(16'hFFFF, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, nv, lc);
        chk("t3_nvalid", 64'(nv), 64'd32);
        chk("t3_bits", 64'(cap), 64'h0000FFFF);

        // load pulsed mid-frame must be ignored.
        do_reset();
        send(16'h00FF, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, nv, lc);
        chk("t4_nvalid", 64'(nv), 64'd16);
        chk("t4_bits", 64'(cap[15:0]), 64'h00FF);
        chk("t4_no_extra_frame", 64'(so_valid), 64'd0);
        chk("t4_bits_drained", 64'(exp_bits.size()), 64'd0);

        // Row parity: pixels 1..32.
        do_reset();
        for (int k = 0; k < 16; k++)
            send({8'(2 * k + 1), 8'(2 * k + 2)}, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, nv, lc);
        chk("t5_wr_count", 64'(wr_log.size()), 64'd32);
        if (wr_log.size() >= 32) begin
            chk("t5_p16", 64'({wr_log[16].oh, 3'b0, wr_log[16].addr, wr_log[16].data}), 64'h02_08_11);
            chk("t5_p17", 64'({wr_log[17].oh, 3'b0, wr_log[17].addr, wr_log[17].data}), 64'h01_08_12);
            chk("t5_p31", 64'({wr_log[31].oh, 3'b0, wr_log[31].addr, wr_log[31].data}), 64'h01_0F_20);
        end

        // Single end frame, then padding and finish.
        do_reset();
        send(16'hBEEF, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, nv, lc);
        t = 0;
        while (!oem_finish && t < 400) begin @(negedge clk); t++; end
        fin_cyc = cyc;
        chk("t6_finish", 64'(oem_finish), 64'd1);
        repeat (2) @(negedge clk);
        chk("t6_wr_count", 64'(wr_log.size()), 64'd256);
        if (wr_log.size() >= 256) begin
            chk("t6_w0_data", 64'(wr_log[0].data), 64'hBE);
            chk("t6_w1_data", 64'(wr_log[1].data), 64'hEF);
            chk("t6_w1_cycle", 64'(wr_log[1].cyc - lc), 64'd17);
            chk("t6_last_cycle", 64'(wr_log[255].cyc - lc), 64'd271);
            chk("t6_pad_back_to_back", 64'(wr_log[255].cyc - wr_log[1].cyc), 64'd254);
            chk("t6_last_pad_data", 64'(wr_log[255].data), 64'h00);
        end
        chk("t6_finish_cycle", 64'(fin_cyc - lc), 64'd272);
        chk("t6_wr_drained", 64'(exp_wr.size()), 64'd0);
        load = 1'b1; pi_end = 1'b0;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_done_so_valid", 64'(so_valid), 64'd0);
        chk("t6_done_finish_held", 64'(oem_finish), 64'd1);
        chk("t6_done_ready", 64'(pi_ready), 64'd0);

        // Reset in the middle of padding aborts immediately.
        do_reset();
        send(16'h1234, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, nv, lc);
        repeat (20) @(negedge clk);
        chk("t7_in_pad", 64'(oem_wr != 8'h0), 64'd1);
        chk_en = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outs("t7_abort");
        reset = 1'b0;
        clear_model();
        any_wr = 1'b0; any_fin = 1'b0;
        repeat (20) begin
            @(negedge clk);
            any_wr  |= (oem_wr != 8'h0);
            any_fin |= oem_finish;
        end
        chk("t7_no_wr_after_abort", 64'(any_wr), 64'd0);
        chk("t7_no_finish_after_abort", 64'(any_fin), 64'd0);
        chk("t7_ready_after_abort", 64'(pi_ready), 64'd1);

        // Capacity: image full after 128 frames; further pixels are dropped, no padding.
        do_reset();
        for (int k = 0; k < 128; k++)
            send({8'(k), 8'(k) ^ 8'h5A}, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, nv, lc);
        chk("t8_full_count", 64'(wr_log.size()), 64'd256);
        send(16'hAAAA, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, nv, lc);
        t = 0;
        while (!oem_finish && t < 50) begin @(negedge clk); t++; end
        chk("t8_finish", 64'(oem_finish), 64'd1);
        repeat (2) @(negedge clk);
        chk("t8_no_extra_writes", 64'(wr_log.size()), 64'd256);
        chk("t8_bits_drained", 64'(exp_bits.size()), 64'd0);
        chk("t8_wr_drained", 64'(exp_wr.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
